// File: rtl/nibble_serial_add_ctrl_pkg.sv
// ============================================================================
// nibble_serial_add_ctrl_pkg : shared sizes and FSM encoding for the
// nibble-serial adder.  Rev 1.0
// ============================================================================
`default_nettype none

package nibble_serial_add_ctrl_pkg;

  localparam int NIB_W_DEF   = 4;
  localparam int NIBBLES_DEF = 4;
  localparam int W_DEF       = NIB_W_DEF * NIBBLES_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // A single-nibble configuration still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_serial_add_ctrl_cpa.sv
// ============================================================================
// nibble_cpa : purely combinational NIB_W-bit ripple-carry adder slice.
// Rev 1.0
// ============================================================================
`default_nettype none

module nibble_cpa #(
  parameter int NIB_W = 4
) (
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIB_W];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
// ============================================================================
// nibble_serial_add_ctrl : W-bit add/subtract sequenced one nibble per clock
// through a single shared adder slice.  Rev 1.0
// ============================================================================
`default_nettype none

module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter  int NIB_W   = NIB_W_DEF,
  parameter  int NIBBLES = NIBBLES_DEF,
  localparam int W       = NIB_W * NIBBLES
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         SUB,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] S,
  output logic         Cout,
  output logic         OVF
);

  localparam int CNT_W = cnt_width(NIBBLES);

  state_t             state;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       res_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [NIB_W-1:0]   slice_s;
  logic               slice_c;
  logic [W-1:0]       res_next;
  logic               last_nib;

  nibble_cpa #(.NIB_W(NIB_W)) u_cpa (
    .a    (a_q[NIB_W-1:0]),
    .b    (b_q[NIB_W-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  // Result fills from the top so the first (least significant) nibble lands at bit 0.
  assign res_next = {slice_s, res_q[W-1:NIB_W]};
  assign last_nib = (cnt_q == CNT_W'(NIBBLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      S       <= '0;
      Cout    <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE, ST_FIN: begin
          if (START) begin
            a_q     <= A;
            b_q     <= SUB ? ~B : B;
            carry_q <= SUB;
            cnt_q   <= '0;
            BUSY    <= 1'b1;
            state   <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          res_q   <= res_next;
          carry_q <= slice_c;
          a_q     <= a_q >> NIB_W;
          b_q     <= b_q >> NIB_W;
          cnt_q   <= cnt_q + 1'b1;
          if (last_nib) begin
            // On the final nibble the slice low nibble holds the operand MSBs.
            state <= ST_FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            S     <= res_next;
            Cout  <= slice_c;
            OVF   <= (a_q[NIB_W-1] == b_q[NIB_W-1]) &&
                     (slice_s[NIB_W-1] != a_q[NIB_W-1]);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
// ============================================================================
// tb_nibble_serial_add_ctrl : directed and randomized checks of the
// nibble-serial adder against a plain-arithmetic model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_add_ctrl;

  localparam int NIB = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        SUB;
  logic [15:0] A;
  logic [15:0] B;
  logic        BUSY;
  logic        DONE;
  logic [15:0] S;
  logic        Cout;
  logic        OVF;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  nibble_serial_add_ctrl dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .SUB   (SUB),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .S     (S),
    .Cout  (Cout),
    .OVF   (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Returns {ovf, cout, s} from plain W+1-bit arithmetic.
  function automatic logic [17:0] model_op(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic [15:0] bb;
    logic [16:0] f;
    logic        o;
    bb = sub ? ~b : b;
    f  = {1'b0, a} + {1'b0, bb} + {16'd0, sub};
    o  = (a[15] == bb[15]) && (f[15] != a[15]);
    return {o, f[16], f[15:0]};
  endfunction

  // Model: expected outputs for the current cycle, then advance with inputs
  // that the next rising edge will sample.
  int          run_left = 0;
  logic        m_done   = 1'b0;
  logic [17:0] m_out    = '0;
  logic [17:0] pend     = '0;

  always @(negedge CLK) begin
    if (RST) begin
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_done", {31'd0, DONE}, 32'd0);
      chk("rst_res", {14'd0, OVF, Cout, S}, 32'd0);
      run_left = 0;
      m_done   = 1'b0;
      m_out    = '0;
    end else begin
      chk("busy", {31'd0, BUSY}, {31'd0, run_left > 0});
      chk("done", {31'd0, DONE}, {31'd0, m_done});
      chk("result", {14'd0, OVF, Cout, S}, {14'd0, m_out});
      if (DONE) done_cnt++;
      m_done = 1'b0;
      if (run_left > 0) begin
        run_left--;
        if (run_left == 0) begin
          m_done = 1'b1;
          m_out  = pend;
        end
      end else if (START) begin
        run_left = NIB;
        pend     = model_op(A, B, SUB);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Waits for DONE (bounded), returning cycles waited and BUSY-high samples.
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (!DONE && n < 12) begin
      if (BUSY) nbusy++;
      tick();
      n++;
    end
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                    input logic [15:0] es, input logic ec, input logic eo, input string name);
    int n, nb;
    A = a; B = b; SUB = sub; START = 1'b1;
    tick();
    START = 1'b0;
    wait_done(n, nb);
    chk({name, "_latency"}, n, 32'd4);
    chk({name, "_busy_cycles"}, nb, 32'd4);
    chk({name, "_s"}, {16'd0, S}, {16'd0, es});
    chk({name, "_cout"}, {31'd0, Cout}, {31'd0, ec});
    chk({name, "_ovf"}, {31'd0, OVF}, {31'd0, eo});
    tick();
  endtask

  initial begin
    int n, nb, d0;
    RST = 1'b1; START = 1'b0; SUB = 1'b0; A = '0; B = '0;
    #1;
    chk("reset_outputs", {13'd0, BUSY, DONE, OVF, Cout, S}, 32'd0);
    tick();
    tick();
    RST = 1'b0;
    tick();

    op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "add");
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub");
    op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");

    // START re-pulsed while busy must be ignored.
    d0 = done_cnt;
    A = 16'h1234; B = 16'h0FFF; SUB = 1'b0; START = 1'b1;
    tick();
    A = 16'h0001; B = 16'h0001;
    tick();
    tick();
    START = 1'b0;
    wait_done(n, nb);
    chk("ignore_s", {16'd0, S}, 32'h2233);
    repeat (10) tick();
    chk("ignore_done_count", done_cnt - d0, 32'd1);

    // Back-to-back: START held through FIN.
    A = 16'h1234; B = 16'h0FFF; SUB = 1'b0; START = 1'b1;
    tick();
    wait_done(n, nb);
    chk("b2b_first_s", {16'd0, S}, 32'h2233);
    A = 16'h7FFF; B = 16'h0001;
    tick();
    START = 1'b0;
    chk("b2b_busy_again", {31'd0, BUSY}, 32'd1);
    wait_done(n, nb);
    chk("b2b_spacing", n + 1, 32'd5);
    chk("b2b_second", {15'd0, OVF, Cout, S}, {15'd0, 1'b1, 1'b0, 16'h8000});
    tick();

    // Reset after two nibbles aborts the operation.
    d0 = done_cnt;
    A = 16'h1234; B = 16'h0FFF; SUB = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    #1;
    chk("abort_immediate", {14'd0, BUSY, OVF, Cout, S}, 32'd0);
    tick();
    RST = 1'b0;
    repeat (8) tick();
    chk("abort_no_done", done_cnt - d0, 32'd0);
    op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, "after_abort");

    // Randomized traffic, occasional resets; the model checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      A     = 16'($urandom);
      B     = 16'($urandom);
      SUB   = 1'($urandom);
      START = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) begin
        RST = 1'b1;
        tick();
        RST = 1'b0;
      end
      tick();
    end
    START = 1'b0;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
